// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the ICache/DCache memory arbiter.
package mem_bus_pkg;
  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DRAIN} arb_state_t;
  typedef enum logic {REQ_ICACHE, REQ_DCACHE} requester_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant logic for I and D with round-robin or fixed D-wins priority.
module rr_arbiter2
  import mem_bus_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_d,
  input  logic accept,
  output logic grant_i,
  output logic grant_d
);

  requester_t last_grant;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (req_i && req_d) begin
      if ((FIXED_PRIORITY != 0) || (last_grant == REQ_ICACHE)) grant_d = 1'b1;
      else grant_i = 1'b1;
    end else begin
      grant_i = req_i;
      grant_d = req_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_DCACHE;
    end else if (accept) begin
      if (grant_i) last_grant <= REQ_ICACHE;
      else if (grant_d) last_grant <= REQ_DCACHE;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the external memory port between ICache misses and DCache accesses,
// holding each request until memory answers and discarding abandoned responses.
module memory_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_read_request,
  input  logic [ADDR_WIDTH-1:0] icache_addr,
  output logic                  icache_read_response,
  output logic [DATA_WIDTH-1:0] icache_read_data,
  input  logic                  dcache_read_request,
  input  logic                  dcache_write_request,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic [DATA_WIDTH-1:0] dcache_write_data,
  output logic                  dcache_read_response,
  output logic                  dcache_write_response,
  output logic [DATA_WIDTH-1:0] dcache_read_data,
  output logic                  memory_read_request,
  output logic                  memory_write_request,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  output logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic                  memory_read_response,
  input  logic                  memory_write_response,
  input  logic [DATA_WIDTH-1:0] memory_read_data
);

  arb_state_t state, state_next;
  logic is_write;
  logic req_d;
  logic idle;
  logic grant_i, grant_d;
  logic owner_req;
  logic mem_rsp;

  assign req_d = dcache_read_request | dcache_write_request;
  assign idle  = (state == IDLE);

  rr_arbiter2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req_i   (icache_read_request),
    .req_d   (req_d),
    .accept  (idle),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // Only the response matching the latched direction counts; the other is spurious.
  assign mem_rsp = is_write ? memory_write_response : memory_read_response;

  always_comb begin
    owner_req = 1'b0;
    if (state == GRANT_I) owner_req = icache_read_request;
    else if (state == GRANT_D) owner_req = is_write ? dcache_write_request : dcache_read_request;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_i) state_next = GRANT_I;
        else if (grant_d) state_next = GRANT_D;
      end
      GRANT_I, GRANT_D: begin
        // A response in the same cycle the owner lets go is still delivered.
        if (mem_rsp) state_next = IDLE;
        else if (!owner_req) state_next = DRAIN;
      end
      DRAIN: begin
        if (mem_rsp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      is_write          <= 1'b0;
      memory_addr       <= '0;
      memory_write_data <= '0;
    end else begin
      state <= state_next;
      if (idle && grant_i) begin
        memory_addr <= icache_addr;
        is_write    <= 1'b0;
      end else if (idle && grant_d) begin
        memory_addr       <= dcache_addr;
        memory_write_data <= dcache_write_data;
        is_write          <= dcache_write_request;
      end
    end
  end

  assign memory_read_request  = !idle && !is_write;
  assign memory_write_request = !idle && is_write;

  assign icache_read_response  = (state == GRANT_I) && memory_read_response;
  assign dcache_read_response  = (state == GRANT_D) && !is_write && memory_read_response;
  assign dcache_write_response = (state == GRANT_D) && is_write && memory_write_response;

  assign icache_read_data = icache_read_response ? memory_read_data : '0;
  assign dcache_read_data = dcache_read_response ? memory_read_data : '0;

endmodule
